// File: rtl/sa_tile_control.sv
// sa_tile_control: K-tiling sequencer for a NUM_ROWS x NUM_COLS systolic array.
// Runs ntiles back-to-back PRELOAD/STREAM passes. Every tile after the first
// reads back partial sums and accumulates into the same output rows.
module sa_tile_control #(
  parameter int NUM_ROWS  = 4,
  parameter int NUM_COLS  = 4,
  parameter int MAX_TILES = 16,
  parameter int MEM_LAT   = 1,
  parameter int ADDR_W    = 16,
  parameter int TILE_W    = $clog2(MAX_TILES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [TILE_W-1:0] i_num_tiles,
  input  logic              i_stall,
  input  logic              i_abort,
  output logic              r_weight_en,
  output logic [ADDR_W-1:0] r_weight_addr,
  output logic              r_input_en,
  output logic [ADDR_W-1:0] r_input_addr,
  output logic              r_psum_en,
  output logic [ADDR_W-1:0] r_psum_addr,
  output logic              w_output_en,
  output logic [ADDR_W-1:0] w_output_addr,
  output logic              o_mode,
  output logic              o_load_psum,
  output logic              o_busy,
  output logic              o_done
);

  localparam int IN_LEN   = NUM_ROWS + NUM_COLS - 1;
  localparam int W0       = IN_LEN;
  localparam int T_STREAM = IN_LEN + NUM_COLS;
  localparam int CNT_W    = $clog2(T_STREAM + 1);
  // Psum reads lead the matching output write by MEM_LAT cycles.
  localparam int PS_LO    = W0 - MEM_LAT;
  localparam int PS_HI    = W0 + NUM_COLS - 1 - MEM_LAT;

  typedef enum logic [1:0] {IDLE, PRELOAD, STREAM} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count_r;
  logic [TILE_W-1:0] tile_r;
  logic [TILE_W-1:0] ntiles_r;
  logic              done_r;

  logic [TILE_W-1:0] ntiles_clamped;
  logic              last_tile;

  logic              weight_en_dec;
  logic              input_en_dec;
  logic              psum_en_dec;
  logic              output_en_dec;
  logic [ADDR_W-1:0] tile_a;
  logic [ADDR_W-1:0] count_a;

  assign tile_a    = ADDR_W'(tile_r);
  assign count_a   = ADDR_W'(count_r);
  assign last_tile = (tile_r == ntiles_r - TILE_W'(1));

  // Requested tile count mapped into 1..MAX_TILES.
  always_comb begin
    ntiles_clamped = i_num_tiles;
    if (i_num_tiles == '0)
      ntiles_clamped = TILE_W'(1);
    else if (i_num_tiles > TILE_W'(MAX_TILES))
      ntiles_clamped = TILE_W'(MAX_TILES);
  end

  // Sequencer: phase/tile counters, stall hold, abort, and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count_r  <= '0;
      tile_r   <= '0;
      ntiles_r <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (i_abort && state != IDLE) begin
        state    <= IDLE;
        count_r  <= '0;
        tile_r   <= '0;
        ntiles_r <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (i_start) begin
              state    <= PRELOAD;
              ntiles_r <= ntiles_clamped;
              count_r  <= '0;
              tile_r   <= '0;
            end
          end
          PRELOAD: begin
            if (!i_stall) begin
              if (count_r == CNT_W'(NUM_ROWS - 1)) begin
                state   <= STREAM;
                count_r <= '0;
              end else begin
                count_r <= count_r + CNT_W'(1);
              end
            end
          end
          STREAM: begin
            if (!i_stall) begin
              if (count_r == CNT_W'(T_STREAM - 1)) begin
                count_r <= '0;
                if (last_tile) begin
                  state  <= IDLE;
                  tile_r <= '0;
                  done_r <= 1'b1;
                end else begin
                  state  <= PRELOAD;
                  tile_r <= tile_r + TILE_W'(1);
                end
              end else begin
                count_r <= count_r + CNT_W'(1);
              end
            end
          end
          default: begin
            state   <= IDLE;
            count_r <= '0;
            tile_r  <= '0;
          end
        endcase
      end
    end
  end

  // Decode memory ports and array mode from state, count and tile.
  always_comb begin
    weight_en_dec = 1'b0;
    input_en_dec  = 1'b0;
    psum_en_dec   = 1'b0;
    output_en_dec = 1'b0;
    r_weight_addr = '0;
    r_input_addr  = '0;
    r_psum_addr   = '0;
    w_output_addr = '0;
    o_mode        = 1'b0;
    o_load_psum   = 1'b0;
    case (state)
      PRELOAD: begin
        weight_en_dec = 1'b1;
        r_weight_addr = tile_a * ADDR_W'(NUM_ROWS) + count_a;
      end
      STREAM: begin
        o_mode      = 1'b1;
        o_load_psum = (tile_r != '0);
        if (count_r < CNT_W'(IN_LEN)) begin
          input_en_dec = 1'b1;
          r_input_addr = tile_a * ADDR_W'(IN_LEN) + count_a;
        end
        // Output rows are rewritten at the same addresses on every tile.
        if (count_r >= CNT_W'(W0) && count_r <= CNT_W'(W0 + NUM_COLS - 1)) begin
          output_en_dec = 1'b1;
          w_output_addr = count_a - ADDR_W'(W0);
        end
        if (tile_r != '0 && count_r >= CNT_W'(PS_LO) && count_r <= CNT_W'(PS_HI)) begin
          psum_en_dec = 1'b1;
          r_psum_addr = count_a - ADDR_W'(PS_LO);
        end
      end
      default: begin
      end
    endcase
  end

  // A stall suppresses every enable while addresses stay on the held value.
  assign r_weight_en = weight_en_dec & ~i_stall;
  assign r_input_en  = input_en_dec  & ~i_stall;
  assign r_psum_en   = psum_en_dec   & ~i_stall;
  assign w_output_en = output_en_dec & ~i_stall;

  assign o_busy = (state != IDLE);
  assign o_done = done_r;

endmodule

// File: tb/tb_sa_tile_control.sv
// Testbench for sa_tile_control (4x4 array, MEM_LAT=1): table of tile-count
// jobs walked cycle by cycle, plus stall, abort, reset and busy-start sequences.
module tb_sa_tile_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [4:0]  i_num_tiles;
  logic        i_stall;
  logic        i_abort;
  logic        r_weight_en;
  logic [15:0] r_weight_addr;
  logic        r_input_en;
  logic [15:0] r_input_addr;
  logic        r_psum_en;
  logic [15:0] r_psum_addr;
  logic        w_output_en;
  logic [15:0] w_output_addr;
  logic        o_mode;
  logic        o_load_psum;
  logic        o_busy;
  logic        o_done;

  int checks   = 0;
  int failures = 0;
  int busy_cnt = 0;
  int in5_cnt  = 0;

  logic [71:0] outs;
  assign outs = {r_weight_en, r_weight_addr, r_input_en, r_input_addr,
                 r_psum_en, r_psum_addr, w_output_en, w_output_addr,
                 o_mode, o_load_psum, o_busy, o_done};

  sa_tile_control #(
    .NUM_ROWS(4), .NUM_COLS(4), .MAX_TILES(16), .MEM_LAT(1), .ADDR_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num_tiles(i_num_tiles),
    .i_stall(i_stall), .i_abort(i_abort),
    .r_weight_en(r_weight_en), .r_weight_addr(r_weight_addr),
    .r_input_en(r_input_en), .r_input_addr(r_input_addr),
    .r_psum_en(r_psum_en), .r_psum_addr(r_psum_addr),
    .w_output_en(w_output_en), .w_output_addr(w_output_addr),
    .o_mode(o_mode), .o_load_psum(o_load_psum), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // Running counters of busy cycles and input-address-5 reads.
  always @(negedge clk) begin
    if (o_busy) busy_cnt++;
    if (r_input_en && r_input_addr == 16'd5) in5_cnt++;
  end

  // Expected output vector for a 4x4 array: IN_LEN=7, writes at 7..10, psum at 6..9.
  function automatic logic [71:0] expv(int ph, int t, int c, bit stl, bit dn);
    logic we = 1'b0, ie = 1'b0, pe = 1'b0, oe = 1'b0, md = 1'b0, ld = 1'b0;
    logic [15:0] wa = '0, ia = '0, pa = '0, oa = '0;
    if (ph == 1) begin
      we = 1'b1;
      wa = 16'(t * 4 + c);
    end else if (ph == 2) begin
      md = 1'b1;
      ld = (t != 0);
      if (c < 7) begin ie = 1'b1; ia = 16'(t * 7 + c); end
      if (c >= 7 && c <= 10) begin oe = 1'b1; oa = 16'(c - 7); end
      if (t != 0 && c >= 6 && c <= 9) begin pe = 1'b1; pa = 16'(c - 6); end
    end
    if (stl) begin we = 1'b0; ie = 1'b0; pe = 1'b0; oe = 1'b0; end
    return {we, wa, ie, ia, pe, pa, oe, oa, md, ld, (ph != 0), dn};
  endfunction

  task automatic chk(string name, logic [71:0] act_v, logic [71:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act_v, exp_v);
    end
  endtask

  task automatic chk_int(string name, int act_v, int exp_v);
    checks++;
    if (act_v != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act_v, exp_v);
    end
  endtask

  // One clock: compare at the falling edge, then step past the rising edge.
  task automatic cycle(string name, logic [71:0] e);
    @(negedge clk);
    chk(name, outs, e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(string tag, int n_in, int n_exp, bit busy_start, int exp_cycles);
    int base = busy_cnt;
    i_start     = 1'b1;
    i_num_tiles = 5'(n_in);
    cycle({tag, " start"}, expv(0, 0, 0, 0, 0));
    i_start = 1'b0;
    for (int t = 0; t < n_exp; t++) begin
      for (int c = 0; c < 4; c++) begin
        i_start = busy_start && t == 0 && (c == 1 || c == 2);
        cycle($sformatf("%s t%0d pre c%0d", tag, t, c), expv(1, t, c, 0, 0));
      end
      i_start = 1'b0;
      for (int c = 0; c < 11; c++)
        cycle($sformatf("%s t%0d str c%0d", tag, t, c), expv(2, t, c, 0, 0));
    end
    cycle({tag, " done"}, expv(0, 0, 0, 0, 1));
    cycle({tag, " after_done"}, expv(0, 0, 0, 0, 0));
    if (busy_start)
      for (int k = 0; k < 3; k++) cycle({tag, " no_second_job"}, expv(0, 0, 0, 0, 0));
    chk_int({tag, " busy_cycles"}, busy_cnt - base, exp_cycles);
    $display("job %s n_in=%0d tiles=%0d busy=%0d", tag, n_in, n_exp, busy_cnt - base);
  endtask

  typedef struct {
    int n_in;
    int n_exp;
    bit busy_start;
    int exp_cycles;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base;
    int base5;
    vecs = '{'{1, 1, 1'b0, 15}, '{3, 3, 1'b0, 45}, '{0, 1, 1'b0, 15},
             '{19, 16, 1'b0, 240}, '{2, 2, 1'b1, 30}, '{16, 16, 1'b0, 240}};
    rst_n = 1'b0; i_start = 1'b0; i_num_tiles = '0; i_stall = 1'b0; i_abort = 1'b0;
    #3;
    chk("reset_outputs", outs, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle("idle_after_reset", expv(0, 0, 0, 0, 0));

    for (int v = 0; v < 6; v++)
      run_job($sformatf("vec%0d", v), vecs[v].n_in, vecs[v].n_exp, vecs[v].busy_start,
              vecs[v].exp_cycles);

    // Stall for 3 cycles at STREAM count 5 of tile 0.
    base = busy_cnt;
    base5 = in5_cnt;
    i_start = 1'b1; i_num_tiles = 5'd1;
    cycle("stall start", expv(0, 0, 0, 0, 0));
    i_start = 1'b0;
    for (int c = 0; c < 4; c++) cycle($sformatf("stall pre c%0d", c), expv(1, 0, c, 0, 0));
    for (int c = 0; c < 5; c++) cycle($sformatf("stall str c%0d", c), expv(2, 0, c, 0, 0));
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) cycle($sformatf("stall held%0d", k), expv(2, 0, 5, 1, 0));
    i_stall = 1'b0;
    for (int c = 5; c < 11; c++) cycle($sformatf("stall str c%0d", c), expv(2, 0, c, 0, 0));
    cycle("stall done", expv(0, 0, 0, 0, 1));
    chk_int("stall busy_cycles", busy_cnt - base, 18);
    chk_int("stall input_addr5_once", in5_cnt - base5, 1);
    $display("stall sequence busy=%0d addr5_reads=%0d", busy_cnt - base, in5_cnt - base5);

    // Abort during tile 1 PRELOAD, then a fresh start from tile 0.
    i_start = 1'b1; i_num_tiles = 5'd3;
    cycle("abort start", expv(0, 0, 0, 0, 0));
    i_start = 1'b0;
    for (int c = 0; c < 4; c++) cycle($sformatf("abort t0 pre c%0d", c), expv(1, 0, c, 0, 0));
    for (int c = 0; c < 11; c++) cycle($sformatf("abort t0 str c%0d", c), expv(2, 0, c, 0, 0));
    for (int c = 0; c < 2; c++) cycle($sformatf("abort t1 pre c%0d", c), expv(1, 1, c, 0, 0));
    i_abort = 1'b1;
    i_stall = 1'b1;
    cycle("abort edge", expv(1, 1, 2, 1, 0));
    i_abort = 1'b0;
    i_stall = 1'b0;
    cycle("abort idle", expv(0, 0, 0, 0, 0));
    cycle("abort no_done", expv(0, 0, 0, 0, 0));
    $display("abort sequence busy=%0b done=%0b", o_busy, o_done);
    run_job("post_abort", 1, 1, 1'b0, 15);

    // Asynchronous reset in the middle of STREAM.
    i_start = 1'b1; i_num_tiles = 5'd2;
    cycle("rst start", expv(0, 0, 0, 0, 0));
    i_start = 1'b0;
    for (int c = 0; c < 4; c++) cycle($sformatf("rst pre c%0d", c), expv(1, 0, c, 0, 0));
    for (int c = 0; c < 4; c++) cycle($sformatf("rst str c%0d", c), expv(2, 0, c, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst async_zero", outs, '0);
    @(posedge clk);
    #1;
    chk("rst held_zero", outs, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) cycle($sformatf("rst idle%0d", k), expv(0, 0, 0, 0, 0));
    $display("async reset sequence outputs=%h", outs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_tile_control.md
Name: sa_tile_control

Overview:
- Next-generation systolic-array sequencer for K-dimension tiling: runs a programmable number of weight tiles back to back through a NUM_ROWS x NUM_COLS array.
- For every tile after the first, it reads back the partial sums and has the array accumulate into them.
- Drives the weight, input, psum-read and output-write memory ports plus the array mode controls.
- Adds stall and abort, runtime tile count, and psum read lead for a configurable memory read latency.

Parameters:
NUM_ROWS, 4, array rows; also weight preload cycles per tile
NUM_COLS, 4, array columns; also output rows written per tile
MAX_TILES, 16, maximum tile count; must be >= 2
MEM_LAT, 1, psum memory read latency in cycles; legal range 0..NUM_ROWS+NUM_COLS-1
ADDR_W, 16, width of every memory address port
TILE_W, $clog2(MAX_TILES+1), width of the tile-count input

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
i_start  in  1  start request; sampled only in IDLE
i_num_tiles  in  TILE_W  tiles to run; latched on an accepted start; 0 is treated as 1; values above MAX_TILES are clamped to MAX_TILES
i_stall  in  1  freeze request from the memory subsystem
i_abort  in  1  synchronous abort
r_weight_en  out  1  weight read enable
r_weight_addr  out  ADDR_W  weight read address
r_input_en  out  1  activation read enable
r_input_addr  out  ADDR_W  activation read address
r_psum_en  out  1  partial-sum read enable
r_psum_addr  out  ADDR_W  partial-sum read address
w_output_en  out  1  output write enable
w_output_addr  out  ADDR_W  output write address
o_mode  out  1  0 = array in preload mode, 1 = array in compute mode
o_load_psum  out  1  1 = array adds the incoming psum; 0 = psum is treated as zero
o_busy  out  1  high whenever the state is not IDLE
o_done  out  1  one-cycle completion pulse

Behaviour:
- Derived constants:
  - IN_LEN = NUM_ROWS+NUM_COLS-1
  - W0 = IN_LEN
  - T_STREAM = IN_LEN+NUM_COLS
- Internal registers: state, count_r (phase counter), tile_r (current tile), ntiles_r (latched tile count).
- States and transitions:
  - IDLE: i_start=1 → PRELOAD; ntiles_r latched; count_r=0; tile_r=0.
  - PRELOAD: count_r counts 0..NUM_ROWS-1, then → STREAM with count_r=0.
  - STREAM: count_r counts 0..T_STREAM-1. At the last count:
    - if tile_r < ntiles_r-1: → PRELOAD, tile_r+1;
    - otherwise → IDLE.
- Outputs are combinational decodes of the registered state, count_r and tile_r (no extra cycle of delay).
- PRELOAD outputs:
  - r_weight_en=1
  - r_weight_addr = tile_r*NUM_ROWS + count_r
  - o_mode=0
- STREAM outputs:
  - r_input_en=1 when count_r < IN_LEN; r_input_addr = tile_r*IN_LEN + count_r
  - w_output_en=1 when W0 <= count_r <= W0+NUM_COLS-1; w_output_addr = count_r-W0
  - The output addresses are the same on every tile, because the outputs are accumulated in place.
  - o_mode=1
  - o_load_psum = (tile_r != 0)
- Psum read (only when tile_r != 0):
  - r_psum_en=1 when W0-MEM_LAT <= count_r <= W0+NUM_COLS-1-MEM_LAT
  - r_psum_addr = count_r-(W0-MEM_LAT), so psum data arrives aligned with the corresponding write.
- Default values: every enable not asserted by the rules above is 0, and its address is 0. o_mode, o_load_psum and the enables are 0 in IDLE.
- Arithmetic: address products and sums are computed at ADDR_W bits and wrap modulo 2^ADDR_W. No saturation.
- Stall (i_stall=1, state not IDLE):
  - state, count_r and tile_r are held;
  - all four enables are forced to 0;
  - addresses, o_mode and o_load_psum keep their decoded values;
  - operation resumes on the first cycle with i_stall=0, with no lost or repeated address.
- Abort: i_abort=1 in any non-IDLE state gives IDLE on the next edge and clears all counters. o_done is not pulsed. Abort has priority over stall.
- o_done:
  - registered;
  - high for exactly one cycle, the first IDLE cycle after a normal completion;
  - low otherwise, including after an abort.
- o_busy = (state != IDLE).
- A start asserted while busy is ignored and not queued. i_start held high in the o_done cycle launches a new job on the next edge.
- Latency with no stalls: ntiles*(NUM_ROWS+T_STREAM) cycles from the accepted-start edge to the o_done edge.
- Reset: state=IDLE, all counters 0. Every output is 0: all enables, all addresses, o_mode, o_load_psum, o_busy, o_done.
- Reset mid-job: outputs go to 0 asynchronously and the job is discarded.

Test Plan:
- 4x4 array, MEM_LAT=1, i_num_tiles=1, start pulse:
  - 4 PRELOAD cycles with weight addr 0..3;
  - 7 input reads, addr 0..6;
  - 4 writes, addr 0..3, at STREAM counts 7..10;
  - r_psum_en never asserted; o_load_psum=0;
  - o_done pulses 15 cycles after the start edge.
- i_num_tiles=3:
  - weight bases 0/4/8; input bases 0/7/14;
  - tiles 1 and 2 have o_load_psum=1, r_psum_en at counts 6..9 with addr 0..3, and writes at counts 7..10 with addr 0..3;
  - o_done pulses after 45 cycles.
- i_num_tiles=0 → behaves exactly like 1 tile. i_num_tiles=MAX_TILES+3 → runs MAX_TILES tiles.
- i_stall=1 for 3 cycles at STREAM count 5 of tile 0:
  - enables are 0 during the stall;
  - input addr 5 is issued exactly once after release;
  - total latency grows by 3.
- i_abort during tile 1 PRELOAD:
  - IDLE on the next cycle with o_busy=0 and no o_done;
  - a following start runs tile 0 from weight addr 0.
- Asynchronous rst_n pulse mid-STREAM → all outputs 0 immediately. i_start while busy → ignored, no second o_done.
